// File: rtl/mux_scan_sel_if.sv
// Bundles the selector's switch inputs, channel data and LED-side outputs.
`timescale 1ns/1ps
interface mux_scan_sel_if #(
    parameter int NR_CH = 4,
    parameter int DW    = 2,
    parameter int SELW  = $clog2(NR_CH)
);
    logic                mode;
    logic                hold;
    logic [SELW-1:0]     sel_in;
    logic [NR_CH*DW-1:0] data_in;
    logic [DW-1:0]       dflt;
    logic [DW-1:0]       dout;
    logic [SELW-1:0]     sel_out;
    logic                upd;

    modport master (
        output mode, hold, sel_in, data_in, dflt,
        input  dout, sel_out, upd
    );

    modport slave (
        input  mode, hold, sel_in, data_in, dflt,
        output dout, sel_out, upd
    );
endinterface

// File: rtl/mux_scan_sel.sv
// Channel selector for the LED bus: debounced manual select or
// prescaled auto-scan, with a default value for out-of-range selects.
`timescale 1ns/1ps
module mux_scan_sel #(
    parameter int NR_CH     = 4,
    parameter int DW        = 2,
    parameter int SELW      = $clog2(NR_CH),
    parameter int SCAN_DIV  = 16,
    parameter int DB_CYCLES = 4
) (
    input logic          clk,
    input logic          rst_n,
    mux_scan_sel_if.slave bus
);
    localparam int PW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [PW-1:0]   PSC_TC = PW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]   DB_N   = CW'(DB_CYCLES);
    localparam logic [SELW-1:0] LAST   = SELW'(NR_CH - 1);

    logic [SELW-1:0] smp;
    logic [SELW-1:0] sel_stable;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;
    logic            mode_q;
    logic            mode_chg;
    logic            tick;
    logic [PW-1:0]   psc;
    logic [SELW-1:0] sel_out;
    logic [SELW-1:0] sel_q;
    logic [DW-1:0]   dmux;
    logic [DW-1:0]   dout;
    logic            upd;

    always_comb begin
        cnt_nxt = cnt;
        if (bus.sel_in != smp)
            cnt_nxt = CW'(1);
        else if (cnt < DB_N)
            cnt_nxt = cnt + 1'b1;
    end

    // stable updates on the cycle the run length reaches DB_CYCLES
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp        <= '0;
            cnt        <= '0;
            sel_stable <= '0;
        end else begin
            smp <= bus.sel_in;
            cnt <= cnt_nxt;
            if (cnt_nxt == DB_N)
                sel_stable <= bus.sel_in;
        end
    end

    assign mode_chg = bus.mode != mode_q;
    assign tick     = (psc == PSC_TC) && !bus.hold && !mode_chg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= 1'b0;
            psc     <= '0;
            sel_out <= '0;
        end else begin
            mode_q <= bus.mode;
            if (mode_chg)
                psc <= '0;
            else if (bus.mode && !bus.hold)
                psc <= (psc == PSC_TC) ? '0 : psc + 1'b1;
            if (!bus.mode)
                sel_out <= sel_stable;
            else if (tick)
                sel_out <= (sel_out >= LAST) ? '0 : sel_out + 1'b1;
        end
    end

    always_comb begin
        dmux = bus.dflt;
        for (int k = 0; k < NR_CH; k++)
            if (sel_out == SELW'(k))
                dmux = bus.data_in[k*DW +: DW];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q <= '0;
            dout  <= '0;
            upd   <= 1'b0;
        end else begin
            sel_q <= sel_out;
            dout  <= dmux;
            upd   <= sel_out != sel_q;
        end
    end

    assign bus.sel_out = sel_out;
    assign bus.dout    = dout;
    assign bus.upd     = upd;
endmodule

// File: tb/tb_mux_scan_sel.sv
// Directed vectors for mux_scan_sel: manual debounce, scan, hold,
// mode toggles, async reset and the out-of-range default path.
`timescale 1ns/1ps
module tb_mux_scan_sel;
    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic       hold = 1'b0;
    logic [1:0] sel_in = 2'd0;
    logic [1:0] dflt = 2'd0;
    logic [7:0] data4 = 8'b11_10_01_00;
    logic [5:0] data3 = 6'b10_01_00;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = clk_en ? ~clk : 1'b0;

    mux_scan_sel_if #(.NR_CH(4), .DW(2)) b4 ();
    mux_scan_sel_if #(.NR_CH(3), .DW(2)) b3 ();

    assign b4.mode = mode;
    assign b4.hold = hold;
    assign b4.sel_in = sel_in;
    assign b4.data_in = data4;
    assign b4.dflt = dflt;
    assign b3.mode = mode;
    assign b3.hold = hold;
    assign b3.sel_in = sel_in;
    assign b3.data_in = data3;
    assign b3.dflt = dflt;

    mux_scan_sel #(
        .NR_CH(4), .DW(2), .SCAN_DIV(4), .DB_CYCLES(4)
    ) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4)
    );

    mux_scan_sel #(
        .NR_CH(3), .DW(2), .SCAN_DIV(4), .DB_CYCLES(4)
    ) u3 (
        .clk(clk), .rst_n(rst_n), .bus(b3)
    );

    typedef struct {
        logic [1:0] sel;
        logic       hld;
        logic [7:0] dat;
        int         n;
        logic [1:0] e_sel;
        logic [1:0] e_dout;
        logic       e_upd;
    } vec_t;

    vec_t tbl [12];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    initial begin
        tbl[0]  = '{2'd0, 1'b0, 8'b11_10_01_00, 3, 2'd0, 2'b00, 1'b0};
        tbl[1]  = '{2'd2, 1'b0, 8'b11_10_01_00, 4, 2'd0, 2'b00, 1'b0};
        tbl[2]  = '{2'd2, 1'b0, 8'b11_10_01_00, 1, 2'd2, 2'b00, 1'b0};
        tbl[3]  = '{2'd2, 1'b0, 8'b11_10_01_00, 1, 2'd2, 2'b10, 1'b1};
        tbl[4]  = '{2'd2, 1'b0, 8'b11_10_01_00, 1, 2'd2, 2'b10, 1'b0};
        tbl[5]  = '{2'd3, 1'b0, 8'b11_10_01_00, 3, 2'd2, 2'b10, 1'b0};
        tbl[6]  = '{2'd2, 1'b0, 8'b11_10_01_00, 6, 2'd2, 2'b10, 1'b0};
        tbl[7]  = '{2'd2, 1'b0, 8'b11_11_01_00, 1, 2'd2, 2'b11, 1'b0};
        tbl[8]  = '{2'd1, 1'b0, 8'b11_11_01_00, 5, 2'd1, 2'b11, 1'b0};
        tbl[9]  = '{2'd1, 1'b0, 8'b11_11_01_00, 1, 2'd1, 2'b01, 1'b1};
        tbl[10] = '{2'd3, 1'b1, 8'b11_11_01_00, 5, 2'd3, 2'b01, 1'b0};
        tbl[11] = '{2'd3, 1'b1, 8'b11_11_01_00, 1, 2'd3, 2'b11, 1'b1};

        #2;
        chk("rst_sel", int'(b4.sel_out), 0);
        chk("rst_dout", int'(b4.dout), 0);
        chk("rst_upd", int'(b4.upd), 0);
        do_reset();

        // manual mode table
        for (int i = 0; i < 12; i++) begin
            sel_in = tbl[i].sel;
            hold = tbl[i].hld;
            data4 = tbl[i].dat;
            step(tbl[i].n);
            chk($sformatf("v%0d_sel", i), int'(b4.sel_out), int'(tbl[i].e_sel));
            chk($sformatf("v%0d_dout", i), int'(b4.dout), int'(tbl[i].e_dout));
            chk($sformatf("v%0d_upd", i), int'(b4.upd), int'(tbl[i].e_upd));
        end

        // back to channel 0, then scan
        hold = 1'b0;
        sel_in = 2'd0;
        data4 = 8'b11_10_01_00;
        step(6);
        chk("pre_scan_sel", int'(b4.sel_out), 0);
        mode = 1'b1;
        step(4);
        chk("scan_first_wait", int'(b4.sel_out), 0);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            chk($sformatf("scan%0d_sel", k), int'(b4.sel_out), k % 4);
            chk($sformatf("scan%0d_upd0", k), int'(b4.upd), 0);
            step(1);
            chk($sformatf("scan%0d_dout", k), int'(b4.dout), k % 4);
            chk($sformatf("scan%0d_upd", k), int'(b4.upd), 1);
            step(2);
            chk($sformatf("scan%0d_keep", k), int'(b4.sel_out), k % 4);
        end

        // hold at prescaler=2
        step(1);
        chk("pre_hold_sel", int'(b4.sel_out), 1);
        step(2);
        hold = 1'b1;
        step(10);
        chk("hold_sel", int'(b4.sel_out), 1);
        chk("hold_upd", int'(b4.upd), 0);
        hold = 1'b0;
        step(1);
        chk("rel1_sel", int'(b4.sel_out), 1);
        step(1);
        chk("rel2_sel", int'(b4.sel_out), 2);

        // one-cycle trip through manual mode restarts the prescaler
        step(1);
        mode = 1'b0;
        step(1);
        chk("tog_manual_sel", int'(b4.sel_out), 0);
        mode = 1'b1;
        step(4);
        chk("tog_wait_sel", int'(b4.sel_out), 0);
        step(1);
        chk("tog_step_sel", int'(b4.sel_out), 1);
        step(8);
        chk("to3_sel", int'(b4.sel_out), 3);

        // async reset with clock stopped
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        #1;
        chk("arst_sel", int'(b4.sel_out), 0);
        chk("arst_dout", int'(b4.dout), 0);
        chk("arst_upd", int'(b4.upd), 0);
        #10;
        rst_n = 1'b1;
        #7;
        clk_en = 1'b1;
        step(1);
        step(3);
        chk("post_arst_wait", int'(b4.sel_out), 0);
        step(1);
        chk("post_arst_step", int'(b4.sel_out), 1);

        // NR_CH=3: out-of-range select shows the default
        mode = 1'b0;
        sel_in = 2'd0;
        do_reset();
        sel_in = 2'd3;
        dflt = 2'b11;
        step(5);
        chk("dflt_sel", int'(b3.sel_out), 3);
        step(1);
        chk("dflt_dout", int'(b3.dout), 3);
        chk("dflt_upd", int'(b3.upd), 1);
        dflt = 2'b10;
        step(1);
        chk("dflt_chg_dout", int'(b3.dout), 2);
        chk("dflt_chg_upd", int'(b3.upd), 0);
        mode = 1'b1;
        step(4);
        chk("dflt_scan_wait", int'(b3.sel_out), 3);
        step(1);
        chk("dflt_scan_sel", int'(b3.sel_out), 0);
        step(1);
        chk("dflt_scan_dout", int'(b3.dout), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end
endmodule
